// File: rtl/serial_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// serial_link_bringup_ctrl
//
// Sequences the power-up of up to NumLinks serial link instances over a simple
// valid/ready register bus. For every link selected in the start mask, in
// ascending index order, it performs:
//   reset deassert -> reset assert -> clock enable -> TX/RX allocator config
//   -> settle wait -> de-isolate -> poll the isolated status until it reads 0
// A bus error response or a poll timeout stops the sequence with error_o set
// and fail_idx_o pointing at the offending link. Links already brought up keep
// their link_up_o bit.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          asynchronous, active-high reset
//   start_i        pulse; starts a sequence when not busy
//   link_mask_i    links to bring up, sampled with an accepted start_i
//   reg_valid_o    register request valid (held until reg_ready_i)
//   reg_write_o    1 = write, 0 = read
//   reg_addr_o     request address
//   reg_wdata_o    write data
//   reg_wstrb_o    byte strobes, always all ones
//   reg_ready_i    request completes in the cycle this is high
//   reg_error_i    error response, qualified by reg_ready_i
//   reg_rdata_i    read data, qualified by reg_ready_i
//   busy_o         sequence in progress
//   done_o         sequence finished successfully (held)
//   error_o        sequence finished with a fault (held)
//   link_up_o      per-link "brought up" flags
//   fail_idx_o     index of the link that caused error_o
// -----------------------------------------------------------------------------
module serial_link_bringup_ctrl #(
    parameter int          NumLinks       = 2,
    parameter logic [31:0] LinkBaseAddr   = 32'h0,
    parameter logic [31:0] LinkStride     = 32'h1000,
    parameter logic [31:0] CtrlOffset     = 32'h0,
    parameter logic [31:0] AllocTxOffset  = 32'h8,
    parameter logic [31:0] AllocRxOffset  = 32'hC,
    parameter logic [31:0] IsolatedOffset = 32'h4,
    parameter int unsigned SettleCycles   = 50,
    parameter int unsigned MaxPolls       = 64,
    localparam int         IdxW           = (NumLinks > 1) ? $clog2(NumLinks) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [NumLinks-1:0] link_mask_i,
    output logic                reg_valid_o,
    output logic                reg_write_o,
    output logic [31:0]         reg_addr_o,
    output logic [31:0]         reg_wdata_o,
    output logic [3:0]          reg_wstrb_o,
    input  logic                reg_ready_i,
    input  logic                reg_error_i,
    input  logic [31:0]         reg_rdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [NumLinks-1:0] link_up_o,
    output logic [IdxW-1:0]     fail_idx_o
);

    // SettleCycles = 0 behaves like 1: the SETTLE state always lasts at least
    // one cycle.
    localparam logic [31:0] SettleLoad = (SettleCycles == 0) ? 32'd0 : 32'(SettleCycles - 1);

    typedef enum logic [3:0] {
        IDLE,
        WR_RST_DEASSERT,
        WR_RST_ASSERT,
        WR_CLK_EN,
        WR_ALLOC_TX,
        WR_ALLOC_RX,
        SETTLE,
        WR_DEISO,
        RD_ISO,
        NEXT,
        DONE,
        ERR
    } state_t;

    state_t              state_reg, state_next;
    logic [IdxW-1:0]     idx_reg, idx_next;
    logic [NumLinks-1:0] mask_reg, mask_next;
    logic [NumLinks-1:0] link_up_reg, link_up_next;
    logic [IdxW-1:0]     fail_idx_reg, fail_idx_next;
    logic [31:0]         settle_cnt_reg, settle_cnt_next;
    logic [31:0]         poll_cnt_reg, poll_cnt_next;
    logic                valid_reg, valid_next;
    logic                write_reg, write_next;
    logic [31:0]         addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;

    // ---------------------------------------------------------------------
    // Link selection helpers
    // ---------------------------------------------------------------------
    logic [IdxW-1:0]     first_idx;
    logic [NumLinks-1:0] above_mask;
    logic [IdxW-1:0]     next_idx;
    logic                has_above;

    // Lowest set bit of the incoming mask: scan downwards so the last hit wins.
    always_comb begin
        first_idx = '0;
        for (int i = NumLinks - 1; i >= 0; i--) begin
            if (link_mask_i[i]) begin
                first_idx = IdxW'(i);
            end
        end
    end

    // Latched mask bits strictly above the current link.
    genvar gi;
    generate
        for (gi = 0; gi < NumLinks; gi++) begin : g_above
            assign above_mask[gi] = mask_reg[gi] && (IdxW'(gi) > idx_reg);
        end
    endgenerate

    always_comb begin
        next_idx = '0;
        for (int i = NumLinks - 1; i >= 0; i--) begin
            if (above_mask[i]) begin
                next_idx = IdxW'(i);
            end
        end
    end

    assign has_above = |above_mask;

    // ---------------------------------------------------------------------
    // Request decode for the current bus state
    // ---------------------------------------------------------------------
    logic [31:0] link_base;
    logic [31:0] issue_off;
    logic [31:0] issue_data;
    logic        issue_write;

    assign link_base = LinkBaseAddr + 32'(idx_reg) * LinkStride;

    always_comb begin
        issue_off   = CtrlOffset;
        issue_data  = 32'h0;
        issue_write = 1'b1;
        case (state_reg)
            WR_RST_DEASSERT: issue_data = 32'h300;
            WR_RST_ASSERT:   issue_data = 32'h302;
            WR_CLK_EN:       issue_data = 32'h303;
            WR_ALLOC_TX: begin
                issue_off  = AllocTxOffset;
                issue_data = 32'h3;
            end
            WR_ALLOC_RX: begin
                issue_off  = AllocRxOffset;
                issue_data = 32'h3;
            end
            WR_DEISO:        issue_data = 32'h03;
            RD_ISO: begin
                issue_off   = IsolatedOffset;
                issue_write = 1'b0;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        mask_next       = mask_reg;
        link_up_next    = link_up_reg;
        fail_idx_next   = fail_idx_reg;
        settle_cnt_next = settle_cnt_reg;
        poll_cnt_next   = poll_cnt_reg;
        valid_next      = valid_reg;
        write_next      = write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    mask_next     = link_mask_i;
                    link_up_next  = '0;
                    fail_idx_next = '0;
                    poll_cnt_next = '0;
                    if (|link_mask_i) begin
                        idx_next   = first_idx;
                        state_next = WR_RST_DEASSERT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            WR_RST_DEASSERT, WR_RST_ASSERT, WR_CLK_EN, WR_ALLOC_TX,
            WR_ALLOC_RX, WR_DEISO, RD_ISO: begin
                // Entering a bus state always finds valid low (either from idle
                // or from the previous completion), which gives the mandatory
                // one-cycle gap between transfers.
                if (!valid_reg) begin
                    valid_next = 1'b1;
                    write_next = issue_write;
                    addr_next  = link_base + issue_off;
                    wdata_next = issue_data;
                end else if (reg_ready_i) begin
                    valid_next = 1'b0;
                    if (reg_error_i) begin
                        state_next    = ERR;
                        fail_idx_next = idx_reg;
                    end else begin
                        case (state_reg)
                            WR_RST_DEASSERT: state_next = WR_RST_ASSERT;
                            WR_RST_ASSERT:   state_next = WR_CLK_EN;
                            WR_CLK_EN:       state_next = WR_ALLOC_TX;
                            WR_ALLOC_TX:     state_next = WR_ALLOC_RX;
                            WR_ALLOC_RX: begin
                                state_next      = SETTLE;
                                settle_cnt_next = SettleLoad;
                            end
                            WR_DEISO:        state_next = RD_ISO;
                            RD_ISO: begin
                                if (reg_rdata_i == 32'h0) begin
                                    link_up_next[idx_reg] = 1'b1;
                                    state_next            = NEXT;
                                end else if (poll_cnt_reg + 32'd1 >= MaxPolls) begin
                                    state_next    = ERR;
                                    fail_idx_next = idx_reg;
                                end else begin
                                    // Stay in RD_ISO; the read is reissued
                                    // after the gap cycle.
                                    poll_cnt_next = poll_cnt_reg + 32'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            SETTLE: begin
                if (settle_cnt_reg == 32'h0) begin
                    state_next = WR_DEISO;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 32'd1;
                end
            end

            NEXT: begin
                if (has_above) begin
                    idx_next      = next_idx;
                    poll_cnt_next = '0;
                    state_next    = WR_RST_DEASSERT;
                end else begin
                    state_next = DONE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            mask_reg       <= '0;
            link_up_reg    <= '0;
            fail_idx_reg   <= '0;
            settle_cnt_reg <= '0;
            poll_cnt_reg   <= '0;
            valid_reg      <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            mask_reg       <= mask_next;
            link_up_reg    <= link_up_next;
            fail_idx_reg   <= fail_idx_next;
            settle_cnt_reg <= settle_cnt_next;
            poll_cnt_reg   <= poll_cnt_next;
            valid_reg      <= valid_next;
            write_reg      <= write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign reg_valid_o = valid_reg;
    assign reg_write_o = write_reg;
    assign reg_addr_o  = addr_reg;
    assign reg_wdata_o = wdata_reg;
    assign reg_wstrb_o = 4'hF;
    assign busy_o      = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERR);
    assign done_o      = (state_reg == DONE);
    assign error_o     = (state_reg == ERR);
    assign link_up_o   = link_up_reg;
    assign fail_idx_o  = fail_idx_reg;

endmodule

// File: tb/tb_serial_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for serial_link_bringup_ctrl.
// A reference model expands each scenario (mask, number of non-zero isolated
// reads per link, optional error-response transaction number) into the
// expected ordered list of bus transactions and the expected final flags.
// A bus responder with random latency checks every transfer against that list.
// -----------------------------------------------------------------------------
module tb_serial_link_bringup_ctrl;

    localparam int          N      = 2;
    localparam logic [31:0] BASE   = 32'h0002_0000;
    localparam logic [31:0] STRIDE = 32'h1000;
    localparam int          MAXP   = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [N-1:0] link_mask_i = '0;
    logic        reg_valid_o, reg_write_o;
    logic [31:0] reg_addr_o, reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_ready_i = 1'b0;
    logic        reg_error_i = 1'b0;
    logic [31:0] reg_rdata_i = '0;
    logic        busy_o, done_o, error_o;
    logic [N-1:0] link_up_o;
    logic [0:0]  fail_idx_o;

    serial_link_bringup_ctrl #(
        .NumLinks     (N),
        .LinkBaseAddr (BASE),
        .LinkStride   (STRIDE),
        .SettleCycles (5),
        .MaxPolls     (MAXP)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .link_mask_i (link_mask_i),
        .reg_valid_o (reg_valid_o),
        .reg_write_o (reg_write_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_ready_i (reg_ready_i),
        .reg_error_i (reg_error_i),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .link_up_o   (link_up_o),
        .fail_idx_o  (fail_idx_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic        exp_done, exp_err;
    logic [N-1:0] exp_up;
    logic [31:0] exp_fail;

    // Bring-up write program of one link: offset and data of each write.
    logic [31:0] w_off [6] = '{32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 32'h0};
    logic [31:0] w_dat [6] = '{32'h300, 32'h302, 32'h303, 32'h3, 32'h3, 32'h03};

    task automatic build_model(input logic [N-1:0] mask, input int nz, input int errt);
        int   n;
        bit   stop;
        logic [31:0] lb;
        exp_q.delete();
        exp_up   = '0;
        exp_err  = 1'b0;
        exp_fail = 32'h0;
        n        = 0;
        stop     = 1'b0;
        for (int l = 0; l < N; l++) begin
            if (mask[l] && !stop) begin
                lb = BASE + 32'(l) * STRIDE;
                for (int s = 0; s < 6 && !stop; s++) begin
                    exp_q.push_back('{1'b1, lb + w_off[s], w_dat[s]});
                    if (n == errt) begin
                        stop = 1'b1; exp_err = 1'b1; exp_fail = 32'(l);
                    end
                    n++;
                end
                for (int p = 0; !stop; p++) begin
                    exp_q.push_back('{1'b0, lb + 32'h4, 32'h0});
                    if (n == errt) begin
                        stop = 1'b1; exp_err = 1'b1; exp_fail = 32'(l);
                    end
                    n++;
                    if (!stop) begin
                        if (p >= nz) begin
                            exp_up[l] = 1'b1;
                            break;
                        end else if (p + 1 == MAXP) begin
                            stop = 1'b1; exp_err = 1'b1; exp_fail = 32'(l);
                        end
                    end
                end
            end
        end
        exp_done = !exp_err;
    endtask

    // ---------------------------------------------------------------------
    // Bus responder and transfer checker (acts on falling edges)
    // ---------------------------------------------------------------------
    int          nz_reads  = 0;
    int          err_txn   = -1;
    bit          stall     = 1'b0;
    int          txn_n     = 0;
    int          rd_cnt    = 0;
    logic [31:0] nz_val    = 32'h3;

    initial begin
        bit          in_txn;
        bit          prev_done;
        int          wait_left;
        logic [31:0] cap_addr;
        txn_t        e;
        in_txn    = 1'b0;
        prev_done = 1'b0;
        wait_left = 0;
        cap_addr  = '0;
        forever begin
            @(negedge clk_i);
            reg_ready_i = 1'b0;
            reg_error_i = 1'b0;
            reg_rdata_i = '0;
            if (rst_i) begin
                in_txn    = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) check_val("gap_valid_low", 32'(reg_valid_o), 32'h0);
                prev_done = 1'b0;
                if (reg_valid_o) begin
                    if (!in_txn) begin
                        in_txn    = 1'b1;
                        cap_addr  = reg_addr_o;
                        wait_left = $urandom_range(0, 2);
                    end else begin
                        check_val("addr_stable", reg_addr_o, cap_addr);
                    end
                    if (!stall) begin
                        if (wait_left == 0) begin
                            in_txn      = 1'b0;
                            prev_done   = 1'b1;
                            reg_ready_i = 1'b1;
                            if (exp_q.size() > 0) e = exp_q.pop_front();
                            else e = '{1'b0, 32'hDEAD_DEAD, 32'h0};
                            $display("txn %0d %s addr=%h wdata=%h", txn_n,
                                     reg_write_o ? "WR" : "RD", reg_addr_o, reg_wdata_o);
                            check_val("txn_write", 32'(reg_write_o), 32'(e.wr));
                            check_val("txn_addr", reg_addr_o, e.addr);
                            check_val("txn_wstrb", 32'(reg_wstrb_o), 32'hF);
                            if (e.wr) check_val("txn_wdata", reg_wdata_o, e.data);
                            if (!reg_write_o) begin
                                reg_rdata_i = (rd_cnt < nz_reads) ? nz_val : 32'h0;
                                rd_cnt++;
                            end else begin
                                rd_cnt = 0;
                            end
                            if (txn_n == err_txn) reg_error_i = 1'b1;
                            txn_n++;
                        end else begin
                            wait_left--;
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Scenario runner
    // ---------------------------------------------------------------------
    task automatic run_case(input logic [N-1:0] mask, input int nz, input int errt,
                            input logic [31:0] nzv);
        int cyc;
        build_model(mask, nz, errt);
        nz_reads = nz;
        err_txn  = errt;
        nz_val   = nzv;
        txn_n    = 0;
        rd_cnt   = 0;
        @(negedge clk_i); #1;
        start_i     = 1'b1;
        link_mask_i = mask;
        @(negedge clk_i); #1;
        // A second start while busy must be ignored.
        if (mask != '0) begin
            link_mask_i = N'($urandom);
            @(negedge clk_i); #1;
        end
        start_i     = 1'b0;
        link_mask_i = N'($urandom);
        cyc = 0;
        while (!(done_o || error_o) && cyc < 5000) begin
            @(negedge clk_i);
            cyc++;
        end
        #1;
        check_val("finish_in_time", 32'(cyc < 5000), 32'h1);
        check_val("done", 32'(done_o), 32'(exp_done));
        check_val("error", 32'(error_o), 32'(exp_err));
        check_val("busy_end", 32'(busy_o), 32'h0);
        check_val("link_up", 32'(link_up_o), 32'(exp_up));
        if (exp_err) check_val("fail_idx", 32'(fail_idx_o), exp_fail);
        check_val("txns_left", 32'(exp_q.size()), 32'h0);
        $display("case mask=%b nz=%0d errt=%0d done=%b error=%b link_up=%b", mask, nz, errt,
                 done_o, error_o, link_up_o);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 32'(reg_valid_o), 32'h0);
        check_val({tag, "_write"}, 32'(reg_write_o), 32'h0);
        check_val({tag, "_addr"}, reg_addr_o, 32'h0);
        check_val({tag, "_wdata"}, reg_wdata_o, 32'h0);
        check_val({tag, "_busy"}, 32'(busy_o), 32'h0);
        check_val({tag, "_done"}, 32'(done_o), 32'h0);
        check_val({tag, "_error"}, 32'(error_o), 32'h0);
        check_val({tag, "_link_up"}, 32'(link_up_o), 32'h0);
        check_val({tag, "_fail_idx"}, 32'(fail_idx_o), 32'h0);
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        int cyc;
        #12;
        check_all_zero("reset");
        @(negedge clk_i); #1;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check_all_zero("idle");

        // Directed scenarios
        run_case(2'b11, 0, -1, 32'h0);          // full bring-up of both links
        run_case(2'b10, 0, -1, 32'h0);          // link 1 only
        run_case(2'b01, 2, -1, 32'h3);          // two non-zero polls then ready
        run_case(2'b01, 99, -1, 32'h1);         // poll timeout on link 0
        run_case(2'b10, 99, -1, 32'h1);         // poll timeout on link 1
        run_case(2'b11, 0, 11, 32'h0);          // error on link 1 WR_ALLOC_RX
        run_case(2'b00, 0, -1, 32'h0);          // empty mask
        run_case(2'b11, 3, 6, 32'h5);           // error on first isolated read

        // Random scenarios
        for (int k = 0; k < 20; k++) begin
            run_case(N'($urandom_range(0, 3)), $urandom_range(0, 5),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1,
                     $urandom | 32'h1);
        end

        // Reset while a transfer is pending with ready withheld.
        stall = 1'b1;
        exp_q.delete();
        @(negedge clk_i); #1;
        start_i     = 1'b1;
        link_mask_i = 2'b11;
        @(negedge clk_i); #1;
        start_i = 1'b0;
        cyc = 0;
        while (!reg_valid_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        check_val("rst_test_valid_seen", 32'(reg_valid_o), 32'h1);
        repeat (4) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk_i); #1;
        rst_i = 1'b0;
        stall = 1'b0;
        repeat (10) @(negedge clk_i);
        #1;
        check_all_zero("post_rst");

        // Normal operation resumes after the mid-transfer reset.
        run_case(2'b11, 1, -1, 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
